// File: rtl/boids_sequencer_if.sv
// -----------------------------------------------------------------------------
// boids_sequencer_if
// Bundle of every non-clock/reset signal of the boids frame sequencer.
//   master : the sequencer itself (drives the live bank, the engine controls,
//            the pixel stream and the status flags)
//   slave  : the surroundings (host config port, update engine, VGA draw stage)
// Signals:
//   frame_start         one-cycle request for a frame update
//   cfg_we/addr/data    live-bank write port (addr = boid*4 + {x,y,vx,vy})
//   boids_attr_array    live bank, word k at index k, Q12.15
//   upd_boid_num        boid index presented to the update engine
//   upd_enable          one-cycle start pulse to the update engine
//   upd_finish          engine idle/done level
//   upd_pos_x/y, upd_vel_x/y  engine results, Q12.15
//   pix_valid/ready     pixel stream handshake
//   pix_x/pix_y         clamped pixel coordinate
//   pix_draw            1 = draw, 0 = erase
//   busy, frame_done, overrun  status
// -----------------------------------------------------------------------------
interface boids_sequencer_if #(
    parameter int NUM_OF_BOIDS = 10,
    parameter int IDX_W        = 13
);
    logic                frame_start;
    logic                cfg_we;
    logic [15:0]         cfg_addr;
    logic [26:0]         cfg_data;
    logic [26:0]         boids_attr_array [NUM_OF_BOIDS*4];
    logic [IDX_W-1:0]    upd_boid_num;
    logic                upd_enable;
    logic                upd_finish;
    logic [26:0]         upd_pos_x;
    logic [26:0]         upd_pos_y;
    logic [26:0]         upd_vel_x;
    logic [26:0]         upd_vel_y;
    logic                pix_valid;
    logic                pix_ready;
    logic [9:0]          pix_x;
    logic [8:0]          pix_y;
    logic                pix_draw;
    logic                busy;
    logic                frame_done;
    logic                overrun;

    modport master (
        input  frame_start, cfg_we, cfg_addr, cfg_data,
        input  upd_finish, upd_pos_x, upd_pos_y, upd_vel_x, upd_vel_y,
        input  pix_ready,
        output boids_attr_array, upd_boid_num, upd_enable,
        output pix_valid, pix_x, pix_y, pix_draw,
        output busy, frame_done, overrun
    );

    modport slave (
        output frame_start, cfg_we, cfg_addr, cfg_data,
        output upd_finish, upd_pos_x, upd_pos_y, upd_vel_x, upd_vel_y,
        output pix_ready,
        input  boids_attr_array, upd_boid_num, upd_enable,
        input  pix_valid, pix_x, pix_y, pix_draw,
        input  busy, frame_done, overrun
    );
endinterface

// File: rtl/boids_sequencer.sv
// -----------------------------------------------------------------------------
// boids_sequencer
// Frame-level controller for the boids system. Owns the live attribute bank
// (x, y, vx, vy per boid, Q12.15), walks every boid through the update engine,
// collects the results in a shadow bank, swaps the shadow bank in at the end
// of the frame and streams one clamped pixel coordinate per boid.
// Ports:
//   clk    system clock
//   reset  synchronous, active-low reset
//   bus    boids_sequencer_if.master (config, engine, pixel stream, status)
// Optional feature macro: BOIDS_SEQ_ERASE_EN
//   defined   : every boid emits an erase beat at its old position followed
//               by a draw beat at its new position
//   undefined : draw beats only, no old-position storage
// -----------------------------------------------------------------------------
module boids_sequencer #(
    parameter int NUM_OF_BOIDS = 10,
    parameter int IDX_W        = 13
) (
    input  logic              clk,
    input  logic              reset,
    boids_sequencer_if.master bus
);
    localparam int NWORDS = NUM_OF_BOIDS * 4;
    localparam int BAW    = (NUM_OF_BOIDS > 1) ? $clog2(NUM_OF_BOIDS) : 1;
    localparam int AW     = BAW + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OF_BOIDS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_ARM     = 3'd2,
        S_WAIT    = 3'd3,
        S_SETTLE  = 3'd4,
        S_CAPTURE = 3'd5,
        S_SWAP    = 3'd6,
        S_EMIT    = 3'd7
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [26:0]       r_live   [NWORDS];
    logic [26:0]       r_shadow [NWORDS];
    logic [IDX_W-1:0]  r_idx;
    logic              r_upd_enable;
    logic              r_busy;
    logic              r_frame_done;
    logic              r_overrun;
    logic              r_pix_valid;
    logic [9:0]        r_pix_x;
    logic [8:0]        r_pix_y;
    logic              r_pix_draw;

    logic              w_cfg_hit;
    logic              w_pix_hs;
    logic              w_last_beat;
    logic              w_load;
    logic [IDX_W-1:0]  w_sel_idx;
    logic [9:0]        w_beat_x;
    logic [8:0]        w_beat_y;
    logic              w_beat_draw;

`ifdef BOIDS_SEQ_ERASE_EN
    logic [9:0]        r_old_x [NUM_OF_BOIDS];
    logic [8:0]        r_old_y [NUM_OF_BOIDS];
    logic              r_phase;
    logic              w_sel_phase;
`endif

    // Integer part of a Q12.15 word clamped to the 640-pixel screen width.
    function automatic logic [9:0] f_clamp_x(input logic [26:0] v);
        logic [9:0] res;
        if (v[26]) begin
            res = 10'd0;
        end else if (v[25:15] > 11'd639) begin
            res = 10'd639;
        end else begin
            res = v[24:15];
        end
        return res;
    endfunction

    // Integer part of a Q12.15 word clamped to the 480-line screen height.
    function automatic logic [8:0] f_clamp_y(input logic [26:0] v);
        logic [8:0] res;
        if (v[26]) begin
            res = 9'd0;
        end else if (v[25:15] > 11'd479) begin
            res = 9'd479;
        end else begin
            res = v[23:15];
        end
        return res;
    endfunction

    // Bank word address of attribute sel (0:x 1:y 2:vx 3:vy) of boid idx.
    function automatic logic [AW-1:0] f_word(input logic [IDX_W-1:0] idx,
                                             input logic [1:0] sel);
        return {idx[BAW-1:0], sel};
    endfunction

    // Config writes land only in IDLE; a simultaneous frame_start wins.
    assign w_cfg_hit = bus.cfg_we && (r_state == S_IDLE) && !bus.frame_start
                       && (bus.cfg_addr < 16'(NWORDS));

    // Pixel-stream sequencing: which beat to present next and when to load it.
    always_comb begin
        w_pix_hs    = r_pix_valid && bus.pix_ready;
        w_sel_idx   = r_idx;
        w_load      = 1'b0;
`ifdef BOIDS_SEQ_ERASE_EN
        w_sel_phase = r_phase;
        w_last_beat = (r_idx == LAST_IDX) && r_phase;
`else
        w_last_beat = (r_idx == LAST_IDX);
`endif
        if (r_state == S_EMIT) begin
            if (!r_pix_valid) begin
                // First beat after SWAP: present the current pointer.
                w_load = 1'b1;
            end else if (w_pix_hs && !w_last_beat) begin
                // Accepted beat: present the following one back-to-back.
                w_load = 1'b1;
`ifdef BOIDS_SEQ_ERASE_EN
                if (!r_phase) begin
                    w_sel_phase = 1'b1;
                end else begin
                    w_sel_phase = 1'b0;
                    w_sel_idx   = r_idx + IDX_W'(1);
                end
`else
                w_sel_idx = r_idx + IDX_W'(1);
`endif
            end else begin
                w_load = 1'b0;
            end
        end else begin
            w_load = 1'b0;
        end
    end

    // Pixel value of the selected beat (draw uses the live bank, erase the latched old position).
    always_comb begin
        w_beat_x    = f_clamp_x(r_live[f_word(w_sel_idx, 2'd0)]);
        w_beat_y    = f_clamp_y(r_live[f_word(w_sel_idx, 2'd1)]);
        w_beat_draw = 1'b1;
`ifdef BOIDS_SEQ_ERASE_EN
        if (!w_sel_phase) begin
            w_beat_x    = r_old_x[w_sel_idx[BAW-1:0]];
            w_beat_y    = r_old_y[w_sel_idx[BAW-1:0]];
            w_beat_draw = 1'b0;
        end else begin
            w_beat_draw = 1'b1;
        end
`endif
    end

    // Next-state logic of the frame FSM.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.frame_start) w_next_state = S_ISSUE;
                else                 w_next_state = S_IDLE;
            end
            S_ISSUE: begin
                if (bus.upd_finish) w_next_state = S_ARM;
                else                w_next_state = S_ISSUE;
            end
            S_ARM: begin
                // Engine must leave its done state before we look for finish again.
                if (!bus.upd_finish) w_next_state = S_WAIT;
                else                 w_next_state = S_ARM;
            end
            S_WAIT: begin
                if (bus.upd_finish) w_next_state = S_SETTLE;
                else                w_next_state = S_WAIT;
            end
            // Engine results become valid one cycle after finish rises.
            S_SETTLE: w_next_state = S_CAPTURE;
            S_CAPTURE: begin
                if (r_idx == LAST_IDX) w_next_state = S_SWAP;
                else                   w_next_state = S_ISSUE;
            end
            S_SWAP: w_next_state = S_EMIT;
            S_EMIT: begin
                if (w_pix_hs && w_last_beat) w_next_state = S_IDLE;
                else                         w_next_state = S_EMIT;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Live bank: host config writes in IDLE, whole-bank swap at frame end.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_live <= '{default: 27'd0};
        end else if (r_state == S_SWAP) begin
            r_live <= r_shadow;
        end else if (w_cfg_hit) begin
            r_live[bus.cfg_addr[AW-1:0]] <= bus.cfg_data;
        end
    end

    // Shadow bank: collects engine results so neighbours keep seeing last frame's data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shadow <= '{default: 27'd0};
        end else if (r_state == S_CAPTURE) begin
            r_shadow[f_word(r_idx, 2'd0)] <= bus.upd_pos_x;
            r_shadow[f_word(r_idx, 2'd1)] <= bus.upd_pos_y;
            r_shadow[f_word(r_idx, 2'd2)] <= bus.upd_vel_x;
            r_shadow[f_word(r_idx, 2'd3)] <= bus.upd_vel_y;
        end
    end

    // Boid pointer, shared by the update walk and the pixel walk.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx <= '0;
        end else if ((r_state == S_IDLE) && bus.frame_start) begin
            r_idx <= '0;
        end else if ((r_state == S_CAPTURE) && (r_idx != LAST_IDX)) begin
            r_idx <= r_idx + IDX_W'(1);
        end else if (r_state == S_SWAP) begin
            r_idx <= '0;
        end else if (w_load) begin
            r_idx <= w_sel_idx;
        end
    end

    // Control outputs; the enable pulse is registered, so the engine sees it while we sit in ARM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_upd_enable <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_upd_enable <= (r_state == S_ISSUE) && bus.upd_finish;
            r_busy       <= (w_next_state != S_IDLE);
            r_frame_done <= (r_state == S_EMIT) && w_pix_hs && w_last_beat;
            r_overrun    <= r_overrun || ((r_state != S_IDLE) && bus.frame_start);
        end
    end

    // Pixel stream registers; values only move on a load, so they hold while stalled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pix_valid <= 1'b0;
            r_pix_x     <= 10'd0;
            r_pix_y     <= 9'd0;
            r_pix_draw  <= 1'b1;
        end else if (w_load) begin
            r_pix_valid <= 1'b1;
            r_pix_x     <= w_beat_x;
            r_pix_y     <= w_beat_y;
            r_pix_draw  <= w_beat_draw;
        end else if (w_pix_hs) begin
            r_pix_valid <= 1'b0;
        end
    end

`ifdef BOIDS_SEQ_ERASE_EN
    // Erase/draw phase and pre-swap positions for the erase beats.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_phase <= 1'b0;
            r_old_x <= '{default: 10'd0};
            r_old_y <= '{default: 9'd0};
        end else if (r_state == S_SWAP) begin
            r_phase <= 1'b0;
            for (int b = 0; b < NUM_OF_BOIDS; b++) begin
                r_old_x[b] <= f_clamp_x(r_live[AW'(4 * b)]);
                r_old_y[b] <= f_clamp_y(r_live[AW'(4 * b + 1)]);
            end
        end else if (w_load) begin
            r_phase <= w_sel_phase;
        end
    end
`endif

    assign bus.boids_attr_array = r_live;
    assign bus.upd_boid_num     = r_idx;
    assign bus.upd_enable       = r_upd_enable;
    assign bus.pix_valid        = r_pix_valid;
    assign bus.pix_x            = r_pix_x;
    assign bus.pix_y            = r_pix_y;
    assign bus.pix_draw         = r_pix_draw;
    assign bus.busy             = r_busy;
    assign bus.frame_done       = r_frame_done;
    assign bus.overrun          = r_overrun;
endmodule

// File: tb/tb_boids_sequencer.sv
// -----------------------------------------------------------------------------
// tb_boids_sequencer
// Directed bench for boids_sequencer with two boids and a behavioural update
// engine (finish drops after enable, rises after a programmable latency,
// results appear one cycle after finish rises).
// -----------------------------------------------------------------------------
module tb_boids_sequencer;
    localparam int NB = 2;
    localparam int IW = 13;
`ifdef BOIDS_SEQ_ERASE_EN
    localparam bit ERASE_MODE = 1'b1;
`else
    localparam bit ERASE_MODE = 1'b0;
`endif

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        logic       d;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    boids_sequencer_if #(.NUM_OF_BOIDS(NB), .IDX_W(IW)) bus ();
    boids_sequencer #(.NUM_OF_BOIDS(NB), .IDX_W(IW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    int    en_count = 0;
    int    en_idx[$];
    int    done_count = 0;
    int    beats_at_done = 0;
    int    eng_lat = 3;
    int    eng_mode = 0;
    logic [26:0] ret_x [NB];
    logic [26:0] ret_y [NB];
    beat_t beats[$];
    beat_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Behavioural update engine.
    initial begin : engine
        int          e_idx;
        logic [26:0] a_x, a_y, a_vx, a_vy;
        bus.upd_finish = 1'b1;
        bus.upd_pos_x  = 27'd0;
        bus.upd_pos_y  = 27'd0;
        bus.upd_vel_x  = 27'd0;
        bus.upd_vel_y  = 27'd0;
        forever begin
            @(posedge clk);
            if (bus.upd_enable === 1'b1) begin
                e_idx = int'(bus.upd_boid_num);
                en_count++;
                en_idx.push_back(e_idx);
                a_x  = bus.boids_attr_array[(e_idx % NB) * 4];
                a_y  = bus.boids_attr_array[(e_idx % NB) * 4 + 1];
                a_vx = bus.boids_attr_array[(e_idx % NB) * 4 + 2];
                a_vy = bus.boids_attr_array[(e_idx % NB) * 4 + 3];
                #1 bus.upd_finish = 1'b0;
                repeat (eng_lat) @(posedge clk);
                #1 bus.upd_finish = 1'b1;
                @(posedge clk);
                #1;
                if (eng_mode == 0) begin
                    bus.upd_pos_x = a_x + 27'h0008000;
                    bus.upd_pos_y = a_y;
                end else begin
                    bus.upd_pos_x = ret_x[e_idx % NB];
                    bus.upd_pos_y = ret_y[e_idx % NB];
                end
                bus.upd_vel_x = a_vx;
                bus.upd_vel_y = a_vy;
            end
        end
    end

    // Pixel-stream and frame_done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        beat_t b;
        if (bus.pix_valid === 1'b1 && bus.pix_ready === 1'b1) begin
            b.x = bus.pix_x;
            b.y = bus.pix_y;
            b.d = bus.pix_draw;
            beats.push_back(b);
        end
        if (bus.frame_done === 1'b1) begin
            done_count++;
            beats_at_done = beats.size();
        end
    end

    task automatic cfg(input logic [15:0] addr, input logic [26:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = addr;
        bus.cfg_data = data;
        tick(1);
        bus.cfg_we   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.frame_start = 1'b1;
        tick(1);
        bus.frame_start = 1'b0;
    endtask

    task automatic push_exp(input int ox, input int oy, input int nx, input int ny);
        beat_t b;
        if (ERASE_MODE) begin
            b.x = 10'(ox); b.y = 9'(oy); b.d = 1'b0;
            exp_q.push_back(b);
        end
        b.x = 10'(nx); b.y = 9'(ny); b.d = 1'b1;
        exp_q.push_back(b);
    endtask

    task automatic wait_en(input int target, input int budget);
        int c = 0;
        while (en_count < target && c < budget) begin
            tick(1);
            c++;
        end
        check($sformatf("enable_%0d_seen", target), 32'(en_count >= target), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int start = done_count;
        int c = 0;
        while (done_count == start && c < budget) begin
            tick(1);
            c++;
        end
        tick(1);
        check("frame_done_once", 32'(done_count - start), 32'd1);
    endtask

    task automatic check_frame(input string name);
        int n;
        check({name, "_beat_count"}, 32'(beats.size()), 32'(exp_q.size()));
        check({name, "_beats_before_done"}, 32'(beats_at_done), 32'(exp_q.size()));
        n = (beats.size() < exp_q.size()) ? beats.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_beat%0d_x", name, i), 32'(beats[i].x), 32'(exp_q[i].x));
            check($sformatf("%s_beat%0d_y", name, i), 32'(beats[i].y), 32'(exp_q[i].y));
            check($sformatf("%s_beat%0d_draw", name, i), 32'(beats[i].d), 32'(exp_q[i].d));
        end
        beats.delete();
        exp_q.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [9:0] hx;
        logic [8:0] hy;
        int         c;
        bus.frame_start = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_addr    = 16'd0;
        bus.cfg_data    = 27'd0;
        bus.pix_ready   = 1'b1;
        ret_x[0] = 27'(-98304);      // -3.0
        ret_y[0] = 27'(22937600);    // 700.0
        ret_x[1] = 27'(22937600);    // 700.0
        ret_y[1] = 27'(-32768);      // -1.0

        // Reset state
        reset = 1'b0;
        tick(3);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_upd_enable", 32'(bus.upd_enable), 32'd0);
        check("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        check("rst_pix_draw", 32'(bus.pix_draw), 32'd1);
        check("rst_pix_x", 32'(bus.pix_x), 32'd0);
        check("rst_pix_y", 32'(bus.pix_y), 32'd0);
        check("rst_boid_num", 32'(bus.upd_boid_num), 32'd0);
        check("rst_attr0", 32'(bus.boids_attr_array[0]), 32'd0);
        reset = 1'b1;
        tick(1);

        // Configure both boids; address 8 is outside the 2-boid bank
        cfg(16'd0, 27'h0324000);   // x0 = 100.5
        cfg(16'd1, 27'h0190000);   // y0 = 50.0
        cfg(16'd2, 27'h0001000);
        cfg(16'd3, 27'h0002000);
        cfg(16'd4, 27'h0050000);   // x1 = 10.0
        cfg(16'd5, 27'h00A0000);   // y1 = 20.0
        cfg(16'd6, 27'h0003000);
        cfg(16'd7, 27'h0004000);
        cfg(16'd8, 27'h7FFFFFF);
        check("cfg_w0", 32'(bus.boids_attr_array[0]), 32'h0324000);
        check("cfg_w5", 32'(bus.boids_attr_array[5]), 32'h00A0000);
        check("cfg_w7", 32'(bus.boids_attr_array[7]), 32'h0004000);

        // Frame 1: engine adds 1.0 to x; a cfg write in the start cycle is dropped
        eng_mode = 0;
        eng_lat  = 3;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 16'd3;
        bus.cfg_data = 27'h1234567;
        pulse_start();
        bus.cfg_we   = 1'b0;
        check("f1_busy", 32'(bus.busy), 32'd1);
        check("f1_cfg_dropped", 32'(bus.boids_attr_array[3]), 32'h0002000);
        push_exp(100, 50, 101, 50);
        push_exp(10, 20, 11, 20);
        wait_done(400);
        check("f1_enable_count", 32'(en_count), 32'd2);
        check("f1_enable_idx0", 32'(en_idx[0]), 32'd0);
        check("f1_enable_idx1", 32'(en_idx[1]), 32'd1);
        check("f1_live_x0", 32'(bus.boids_attr_array[0]), 32'h032C000);
        check("f1_live_y0", 32'(bus.boids_attr_array[1]), 32'h0190000);
        check("f1_live_vx0", 32'(bus.boids_attr_array[2]), 32'h0001000);
        check("f1_live_x1", 32'(bus.boids_attr_array[4]), 32'h0058000);
        check("f1_busy_after", 32'(bus.busy), 32'd0);
        check_frame("f1");

        // Frame 2: slow engine, clamped results, pixel stall at the start of EMIT
        eng_mode      = 1;
        eng_lat       = 20;
        bus.pix_ready = 1'b0;
        pulse_start();
        wait_en(3, 50);
        tick(10);
        check("f2_no_second_enable", 32'(en_count), 32'd3);
        check("f2_boid_num_held", 32'(bus.upd_boid_num), 32'd0);
        check("f2_busy_in_wait", 32'(bus.busy), 32'd1);
        c = 0;
        while (bus.pix_valid !== 1'b1 && c < 400) begin
            tick(1);
            c++;
        end
        check("f2_pix_valid_seen", 32'(bus.pix_valid), 32'd1);
        hx = bus.pix_x;
        hy = bus.pix_y;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check($sformatf("f2_stall%0d_valid", i), 32'(bus.pix_valid), 32'd1);
            check($sformatf("f2_stall%0d_x", i), 32'(bus.pix_x), 32'(hx));
            check($sformatf("f2_stall%0d_y", i), 32'(bus.pix_y), 32'(hy));
        end
        bus.pix_ready = 1'b1;
        push_exp(101, 50, 0, 479);
        push_exp(11, 20, 639, 0);
        wait_done(400);
        check("f2_enable_count", 32'(en_count), 32'd4);
        check_frame("f2");

        // Frame 3: frame_start while waiting on the engine sets overrun
        eng_mode = 0;
        eng_lat  = 6;
        pulse_start();
        wait_en(5, 50);
        tick(3);
        pulse_start();
        check("f3_overrun_set", 32'(bus.overrun), 32'd1);
        push_exp(0, 479, 0, 479);
        push_exp(639, 0, 639, 0);
        wait_done(400);
        check("f3_enable_count", 32'(en_count), 32'd6);
        check("f3_overrun_sticky", 32'(bus.overrun), 32'd1);
        check("f3_busy_after", 32'(bus.busy), 32'd0);
        check_frame("f3");

        // Frame 4: reset while waiting on the engine abandons the frame
        eng_lat = 20;
        pulse_start();
        wait_en(7, 50);
        tick(5);
        c = done_count;
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        check("rw_busy", 32'(bus.busy), 32'd0);
        check("rw_overrun", 32'(bus.overrun), 32'd0);
        check("rw_attr0", 32'(bus.boids_attr_array[0]), 32'd0);
        check("rw_attr5", 32'(bus.boids_attr_array[5]), 32'd0);
        check("rw_upd_enable", 32'(bus.upd_enable), 32'd0);
        tick(40);
        check("rw_no_frame_done", 32'(done_count), 32'(c));
        check("rw_idle_busy", 32'(bus.busy), 32'd0);
        check("rw_idle_pix_valid", 32'(bus.pix_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
